// File: rtl/geodash_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : geodash_pkg
// Description : Shared playfield constants, FSM state type and helpers for
//               the obstacle controller.
// Revision    : 1.0  initial release
// ============================================================================
package geodash_pkg;

  localparam int SCREEN_W    = 640;
  localparam int CEILING_ROW = 42;
  localparam int FLOOR_ROW   = 437;
  localparam int OBS_X_W     = 11;

  typedef logic [OBS_X_W-1:0] obs_x_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  // Unsigned subtract that clamps at zero instead of wrapping.
  function automatic logic [11:0] sat_sub12(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : 12'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : obstacle_controller_if
// Description : Frame/start/ball inputs and obstacle state outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface obstacle_controller_if;
  import geodash_pkg::*;

  logic        frame_clk;
  logic        start;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [9:0]  Ball_size;
  obs_x_t      Triangle_X;
  logic [10:0] Triangle_Y;
  obs_x_t      Column_X;
  logic        is_flipped;
  logic        is_column_flipped;
  logic        will_collide;

  modport master (
    output frame_clk, start, BallX, BallY, Ball_size,
    input  Triangle_X, Triangle_Y, Column_X, is_flipped, is_column_flipped, will_collide
  );

  modport slave (
    input  frame_clk, start, BallX, BallY, Ball_size,
    output Triangle_X, Triangle_Y, Column_X, is_flipped, is_column_flipped, will_collide
  );

endinterface
`default_nettype wire

// File: rtl/obstacle_controller_lfsr8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR, taps 8,6,5,4; steps only when advanced.
// Revision    : 1.0  initial release
// ============================================================================
module lfsr8 (
  input  wire logic       Clk,
  input  wire logic       Reset,
  input  wire logic       advance,
  input  wire logic [7:0] seed,
  output logic      [7:0] q
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= seed;
    end else if (advance) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/obstacle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : obstacle_controller
// Description : Scrolls a spike and a column once per frame, respawns them
//               with random orientation and flags ball/spike overlap.
//               Optional macro OBSTACLE_SPEEDUP_EN: speed grows every 8 wraps.
// Revision    : 1.0  initial release
// ============================================================================
module obstacle_controller
  import geodash_pkg::*;
#(
  parameter int         SCROLL_SPEED = 2,
  parameter int         SPAWN_X      = 660,
  parameter int         COLUMN_LAG   = 320,
  parameter int         FLOOR_TRI_Y  = 428,
  parameter int         CEIL_TRI_Y   = 51,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input wire logic              Clk,
  input wire logic              Reset,
  obstacle_controller_if.slave  bus
);

  localparam obs_x_t      c_spawn_x  = obs_x_t'(SPAWN_X);
  localparam obs_x_t      c_col_init = obs_x_t'(SPAWN_X + COLUMN_LAG);
  localparam logic [10:0] c_floor_y  = 11'(FLOOR_TRI_Y);
  localparam logic [10:0] c_ceil_y   = 11'(CEIL_TRI_Y);

  state_t      r_state, w_state_nxt;
  logic        r_frame_q, w_tick;
  obs_x_t      r_tri_x, w_tri_x_nxt, r_col_x, w_col_x_nxt, w_speed;
  logic [10:0] r_tri_y, w_tri_y_nxt;
  logic        r_flip, w_flip_nxt, r_col_flip, w_col_flip_nxt;
  logic        r_collide, w_collide_nxt;
  logic        w_lfsr_adv, w_tri_wrap, w_col_wrap, w_overlap;
  logic [7:0]  w_lfsr;
  logic [5:0]  w_lfsr_unused;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [2:0] c_speed_init = 3'(SCROLL_SPEED);
  localparam logic [2:0] c_speed_max  = 3'd6;
  logic [2:0] r_speed, w_speed_nxt, r_wrap_cnt, w_wrap_cnt_nxt;
  assign w_speed = obs_x_t'(r_speed);
`else
  assign w_speed = obs_x_t'(SCROLL_SPEED);
`endif

  assign w_tick        = bus.frame_clk & ~r_frame_q;
  assign w_lfsr_unused = w_lfsr[7:2];

  lfsr8 u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .advance (w_lfsr_adv),
    .seed    (LFSR_SEED),
    .q       (w_lfsr)
  );

  // Bounding-box overlap on pre-update positions, 12-bit unsigned.
  logic [11:0] w_tx, w_ty, w_bx, w_by, w_bs;
  logic [11:0] w_tri_l, w_tri_r, w_tri_t, w_tri_b;
  logic [11:0] w_ball_l, w_ball_r, w_ball_t, w_ball_b;

  assign w_tx     = {1'b0, r_tri_x};
  assign w_ty     = {1'b0, r_tri_y};
  assign w_bx     = {2'b00, bus.BallX};
  assign w_by     = {2'b00, bus.BallY};
  assign w_bs     = {2'b00, bus.Ball_size};
  assign w_tri_l  = sat_sub12(w_tx, 12'd7);
  assign w_tri_r  = w_tx + 12'd8;
  assign w_tri_t  = w_ty - (r_flip ? 12'd8 : 12'd4);
  assign w_tri_b  = w_ty + (r_flip ? 12'd4 : 12'd8);
  assign w_ball_l = sat_sub12(w_bx, w_bs);
  assign w_ball_r = w_bx + w_bs;
  assign w_ball_t = sat_sub12(w_by, w_bs);
  assign w_ball_b = w_by + w_bs;

  assign w_overlap = (w_tri_l <= w_ball_r) && (w_ball_l <= w_tri_r) &&
                     (w_tri_t <= w_ball_b) && (w_ball_t <= w_tri_b);

  assign w_tri_wrap = (r_tri_x < w_speed);
  assign w_col_wrap = (r_col_x < w_speed);

  always_comb begin
    w_state_nxt    = r_state;
    w_tri_x_nxt    = r_tri_x;
    w_col_x_nxt    = r_col_x;
    w_tri_y_nxt    = r_tri_y;
    w_flip_nxt     = r_flip;
    w_col_flip_nxt = r_col_flip;
    w_collide_nxt  = r_collide;
    w_lfsr_adv     = 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
    w_speed_nxt    = r_speed;
    w_wrap_cnt_nxt = r_wrap_cnt;
`endif
    case (r_state)
      IDLE, HIT: begin
        // A restart discards any coincident tick.
        if (bus.start) begin
          w_state_nxt    = RUN;
          w_tri_x_nxt    = c_spawn_x;
          w_col_x_nxt    = c_col_init;
          w_tri_y_nxt    = c_floor_y;
          w_flip_nxt     = 1'b0;
          w_col_flip_nxt = 1'b0;
          w_collide_nxt  = 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
          w_speed_nxt    = c_speed_init;
          w_wrap_cnt_nxt = 3'd0;
`endif
        end
      end
      RUN: begin
        if (w_tick) begin
          if (w_overlap) begin
            w_collide_nxt = 1'b1;
            w_state_nxt   = HIT;
          end else begin
            if (w_tri_wrap) begin
              w_tri_x_nxt = c_spawn_x;
              w_flip_nxt  = w_lfsr[0];
              w_tri_y_nxt = w_lfsr[0] ? c_ceil_y : c_floor_y;
`ifdef OBSTACLE_SPEEDUP_EN
              w_wrap_cnt_nxt = r_wrap_cnt + 3'd1;
              if (r_wrap_cnt == 3'd7 && r_speed < c_speed_max) begin
                w_speed_nxt = r_speed + 3'd1;
              end
`endif
            end else begin
              w_tri_x_nxt = r_tri_x - w_speed;
            end
            if (w_col_wrap) begin
              w_col_x_nxt    = c_spawn_x;
              w_col_flip_nxt = w_lfsr[1];
            end else begin
              w_col_x_nxt = r_col_x - w_speed;
            end
            w_lfsr_adv = w_tri_wrap | w_col_wrap;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_frame_q  <= 1'b0;
      r_tri_x    <= c_spawn_x;
      r_col_x    <= c_col_init;
      r_tri_y    <= c_floor_y;
      r_flip     <= 1'b0;
      r_col_flip <= 1'b0;
      r_collide  <= 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
      r_speed    <= c_speed_init;
      r_wrap_cnt <= 3'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_frame_q  <= bus.frame_clk;
      r_tri_x    <= w_tri_x_nxt;
      r_col_x    <= w_col_x_nxt;
      r_tri_y    <= w_tri_y_nxt;
      r_flip     <= w_flip_nxt;
      r_col_flip <= w_col_flip_nxt;
      r_collide  <= w_collide_nxt;
`ifdef OBSTACLE_SPEEDUP_EN
      r_speed    <= w_speed_nxt;
      r_wrap_cnt <= w_wrap_cnt_nxt;
`endif
    end
  end

  assign bus.Triangle_X        = r_tri_x;
  assign bus.Column_X          = r_col_x;
  assign bus.Triangle_Y        = r_tri_y;
  assign bus.is_flipped        = r_flip;
  assign bus.is_column_flipped = r_col_flip;
  assign bus.will_collide      = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_controller
// Description : Vector table plus tick-level reference model for the
//               obstacle controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_obstacle_controller;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam int c_exp_speed = 3;
`else
  localparam int c_exp_speed = 2;
`endif

  typedef struct packed {
    logic [10:0] tx;
    logic [10:0] cx;
    logic [10:0] ty;
    logic        fl;
    logic        cfl;
    logic        wc;
  } snap_t;

  typedef struct {
    int    kind;   // 0: optional start then n ticks, 1: start and tick together
    bit    st;
    int    bx, by, bs;
    int    n;
    snap_t exp;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_controller_if bus();

  obstacle_controller dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  snap_t sb_q[$];
  row_t  rows[9];

  // Reference model
  int         m_tx, m_cx, m_ty, m_state, m_spd, m_wraps;
  bit         m_fl, m_cfl, m_wc;
  logic [7:0] m_lfsr;

  function automatic snap_t mk(int tx, int cx, int ty, bit fl, bit cfl, bit wc);
    snap_t s;
    s.tx = 11'(tx); s.cx = 11'(cx); s.ty = 11'(ty);
    s.fl = fl; s.cfl = cfl; s.wc = wc;
    return s;
  endfunction

  function automatic snap_t m_snap();
    return mk(m_tx, m_cx, m_ty, m_fl, m_cfl, m_wc);
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.tx = bus.Triangle_X; s.cx = bus.Column_X; s.ty = bus.Triangle_Y;
    s.fl = bus.is_flipped; s.cfl = bus.is_column_flipped; s.wc = bus.will_collide;
    return s;
  endfunction

  task automatic m_load();
    m_tx = 660; m_cx = 980; m_ty = 428;
    m_fl = 0; m_cfl = 0; m_wc = 0;
    m_spd = 2; m_wraps = 0;
  endtask

  task automatic m_reset();
    m_load();
    m_state = 0;
    m_lfsr  = 8'hA5;
  endtask

  task automatic m_start();
    if (m_state != 1) begin
      m_load();
      m_state = 1;
    end
  endtask

  task automatic m_tick();
    int txl, txh, tyl, tyh, bxl, bxh, byl, byh, bx, by, bs, spd0;
    bit tw, cw;
    if (m_state != 1) return;
    bx = int'(bus.BallX); by = int'(bus.BallY); bs = int'(bus.Ball_size);
    txl = (m_tx > 7) ? m_tx - 7 : 0;
    txh = m_tx + 8;
    tyl = m_fl ? m_ty - 8 : m_ty - 4;
    tyh = m_fl ? m_ty + 4 : m_ty + 8;
    bxl = (bx > bs) ? bx - bs : 0;
    bxh = bx + bs;
    byl = (by > bs) ? by - bs : 0;
    byh = by + bs;
    if (txl <= bxh && bxl <= txh && tyl <= byh && byl <= tyh) begin
      m_wc = 1;
      m_state = 2;
      return;
    end
    spd0 = m_spd;
    tw = (m_tx < spd0);
    cw = (m_cx < spd0);
    if (tw) begin
      m_fl = m_lfsr[0];
      m_ty = m_fl ? 51 : 428;
      m_tx = 660;
      m_wraps++;
`ifdef OBSTACLE_SPEEDUP_EN
      if (m_wraps % 8 == 0 && m_spd < 6) m_spd++;
`endif
    end else begin
      m_tx -= spd0;
    end
    if (cw) begin
      m_cfl = m_lfsr[1];
      m_cx  = 660;
    end else begin
      m_cx -= spd0;
    end
    if (tw || cw) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic sb_check(input string name);
    snap_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got scoreboard empty, expected a queued result", name);
    end else begin
      e = sb_q.pop_front();
      check(name, 64'(dut_snap()), 64'(e));
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.frame_clk = 1'b1;
    m_tick();
    sb_q.push_back(m_snap());
    @(negedge clk);
    sb_check("tick");
    bus.frame_clk = 1'b0;
  endtask

  task automatic do_start(input bit with_tick);
    @(negedge clk);
    bus.start = 1'b1;
    bus.frame_clk = with_tick;
    m_start();
    sb_q.push_back(m_snap());
    @(negedge clk);
    sb_check(with_tick ? "start_tick" : "start");
    bus.start = 1'b0;
    bus.frame_clk = 1'b0;
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    bus.BallX = 10'(x); bus.BallY = 10'(y); bus.Ball_size = 10'(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rows[0] = '{0, 1, 100, 200, 4, 3,   mk(654, 974, 428, 0, 0, 0)};
    rows[1] = '{0, 1, 100, 200, 4, 167, mk(320, 640, 428, 0, 0, 0)};
    rows[2] = '{0, 0, 320, 428, 4, 1,   mk(320, 640, 428, 0, 0, 1)};
    rows[3] = '{0, 0, 320, 428, 4, 3,   mk(320, 640, 428, 0, 0, 1)};
    rows[4] = '{1, 1, 320, 428, 4, 0,   mk(660, 980, 428, 0, 0, 0)};
    rows[5] = '{0, 0, 100, 200, 4, 1,   mk(658, 978, 428, 0, 0, 0)};
    rows[6] = '{0, 0, 100, 200, 4, 329, mk(0,   320, 428, 0, 0, 0)};
    rows[7] = '{0, 0, 100, 200, 4, 1,   mk(660, 318, 51,  1, 0, 0)};
    rows[8] = '{0, 0, 100, 200, 4, 160, mk(340, 660, 51,  1, 1, 0)};

    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.start = 1'b0;
    set_ball(100, 200, 4);
    m_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dut_snap()), 64'(mk(660, 980, 428, 0, 0, 0)));
    rst = 1'b0;

    // Ticks in IDLE leave everything parked.
    do_tick();
    check("idle_hold", 64'(dut_snap()), 64'(mk(660, 980, 428, 0, 0, 0)));

    foreach (rows[i]) begin
      set_ball(rows[i].bx, rows[i].by, rows[i].bs);
      if (rows[i].kind == 1) begin
        do_start(1'b1);
      end else begin
        if (rows[i].st) do_start(1'b0);
        repeat (rows[i].n) do_tick();
      end
      check($sformatf("row%0d", i), 64'(dut_snap()), 64'(rows[i].exp));
    end

    // Asynchronous reset between clock edges while running.
    do_tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", 64'(dut_snap()), 64'(mk(660, 980, 428, 0, 0, 0)));
    m_reset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Run eight triangle wraps, then measure the per-tick decrement.
    set_ball(100, 200, 4);
    do_start(1'b0);
    for (int i = 0; i < 3000 && m_wraps < 8; i++) do_tick();
    check("wrap8_count", 64'(m_wraps), 64'd8);
    check("wrap8_x", 64'(bus.Triangle_X), 64'd660);
    do_tick();
    check("speed_after_8", 64'(bus.Triangle_X), 64'(660 - c_exp_speed));
    do_tick();
    check("speed_after_8b", 64'(bus.Triangle_X), 64'(660 - 2 * c_exp_speed));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
